// File: rtl/inst_decode_stage.sv
// RV32I decode stage: decodes one instruction into a registered bundle with a one-entry skid buffer.
// Optional macro DECODE_ILLEGAL_EN adds the o_illegal output.
module inst_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PC_W-1:0]  o_pc,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [2:0]       o_funct3,
  output logic             o_funct7_b5,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_reg_write,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_alu_src_imm,
  output logic             o_pc_src
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic             o_illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src_imm;
    logic            pc_src;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } bundle_t;

  bundle_t     dec;
  logic [31:0] imm32;
  logic        known;
  logic        bad_f7;
  logic        illegal;

  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    accept;
  logic    load_out;

  // Combinational decode of the incoming word.
  always_comb begin
    dec       = '0;
    imm32     = '0;
    known     = 1'b1;
    bad_f7    = 1'b0;
    dec.pc        = i_pc;
    dec.rd        = i_inst[11:7];
    dec.rs1       = i_inst[19:15];
    dec.rs2       = i_inst[24:20];
    dec.funct3    = i_inst[14:12];
    dec.funct7_b5 = i_inst[30];
    case (i_inst[6:0])
      OP_R: begin
        dec.reg_write = 1'b1;
        bad_f7 = (i_inst[31:25] != 7'b0000000) && (i_inst[31:25] != 7'b0100000);
      end
      OP_I, OP_LOAD, OP_JALR, OP_SYS: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = (i_inst[6:0] != OP_SYS);
        dec.mem_read    = (i_inst[6:0] == OP_LOAD);
        dec.jump        = (i_inst[6:0] == OP_JALR);
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      OP_STORE: begin
        dec.rd          = '0;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      OP_BRANCH: begin
        dec.rd     = '0;
        dec.branch = 1'b1;
        imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.pc_src      = (i_inst[6:0] == OP_AUIPC);
        imm32 = {i_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.pc_src    = 1'b1;
        imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      default: known = 1'b0;
    endcase
    illegal = (i_inst[1:0] != 2'b11) | !known | bad_f7;
    // Illegal words become a bubble: no side effects downstream.
    if (illegal) begin
      {dec.reg_write, dec.branch, dec.jump, dec.mem_read,
       dec.mem_write, dec.alu_src_imm, dec.pc_src} = '0;
    end
    dec.imm = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = illegal;
`endif
  end

  assign accept   = i_valid & ~skid_valid_q;
  assign load_out = ~out_valid_q | i_ready;

  // Handshake: output register refills from skid first; skid only catches accepts while stalled.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign o_ready       = ~skid_valid_q;
  assign o_valid       = out_valid_q;
  assign o_pc          = out_q.pc;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_funct3      = out_q.funct3;
  assign o_funct7_b5   = out_q.funct7_b5;
  assign o_imm         = out_q.imm;
  assign o_reg_write   = out_q.reg_write;
  assign o_branch      = out_q.branch;
  assign o_jump        = out_q.jump;
  assign o_mem_read    = out_q.mem_read;
  assign o_mem_write   = out_q.mem_write;
  assign o_alu_src_imm = out_q.alu_src_imm;
  assign o_pc_src      = out_q.pc_src;
`ifdef DECODE_ILLEGAL_EN
  assign o_illegal     = out_q.illegal;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: decode values, skid ordering, flush and reset.
module tb_inst_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [31:0] i_inst, i_pc, o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3;
  logic        o_funct7_b5;
  logic        o_reg_write, o_branch, o_jump, o_mem_read, o_mem_write, o_alu_src_imm, o_pc_src;
`ifdef DECODE_ILLEGAL_EN
  logic        o_illegal;
`endif
  logic [6:0]  flags;

  int vectors = 0;
  int miscompares = 0;

  inst_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_funct3(o_funct3), .o_funct7_b5(o_funct7_b5), .o_imm(o_imm),
    .o_reg_write(o_reg_write), .o_branch(o_branch), .o_jump(o_jump),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_alu_src_imm(o_alu_src_imm), .o_pc_src(o_pc_src)
`ifdef DECODE_ILLEGAL_EN
    , .o_illegal(o_illegal)
`endif
  );

  // {reg_write, branch, jump, mem_read, mem_write, alu_src_imm, pc_src}
  assign flags = {o_reg_write, o_branch, o_jump, o_mem_read, o_mem_write, o_alu_src_imm, o_pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    i_valid = v;
    i_inst  = inst;
    i_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_imm", 64'(o_imm), 64'd0);
    rst_n = 1'b1;
    step();

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    chk("addi_valid", 64'(o_valid), 64'd1);
    chk("addi_rd", 64'(o_rd), 64'd1);
    chk("addi_rs1", 64'(o_rs1), 64'd0);
    chk("addi_imm", 64'(o_imm), 64'd5);
    chk("addi_flags", 64'(flags), 64'b1000010);
    chk("addi_pc", 64'(o_pc), 64'h100);
`ifdef DECODE_ILLEGAL_EN
    chk("addi_illegal", 64'(o_illegal), 64'd0);
`endif

    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h104);
    step();
    chk("beq_flags", 64'(flags), 64'b0100000);
    chk("beq_rd", 64'(o_rd), 64'd0);
    chk("beq_imm", 64'(o_imm), 64'hFFFFFFFC);

    // lui x3,0x12345
    drive(1'b1, 32'h123451B7, 32'h108);
    step();
    chk("lui_imm", 64'(o_imm), 64'h12345000);
    chk("lui_flags", 64'(flags), 64'b1000010);
    chk("lui_rd", 64'(o_rd), 64'd3);

    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain_valid", 64'(o_valid), 64'd0);

    // Stall: add lands in output, sw lands in skid, sub is back-pressured
    i_ready = 1'b0;
    drive(1'b1, 32'h007302B3, 32'h200);
    step();
    chk("add_valid", 64'(o_valid), 64'd1);
    chk("add_rs2", 64'(o_rs2), 64'd7);
    chk("add_ready", 64'(o_ready), 64'd1);
    drive(1'b1, 32'h0020A423, 32'h204);
    step();
    chk("stall_ready", 64'(o_ready), 64'd0);
    chk("stall_pc", 64'(o_pc), 64'h200);
    drive(1'b1, 32'h403100B3, 32'h208);
    step();
    chk("stall2_pc", 64'(o_pc), 64'h200);
    chk("stall2_ready", 64'(o_ready), 64'd0);
    i_ready = 1'b1;
    step();
    chk("sw_pc", 64'(o_pc), 64'h204);
    chk("sw_flags", 64'(flags), 64'b0000110);
    chk("sw_imm", 64'(o_imm), 64'd8);
    chk("sw_rd", 64'(o_rd), 64'd0);
    chk("sw_ready", 64'(o_ready), 64'd1);
    step();
    chk("sub_pc", 64'(o_pc), 64'h208);
    chk("sub_f7b5", 64'(o_funct7_b5), 64'd1);
    chk("sub_flags", 64'(flags), 64'b1000000);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("sub_drain", 64'(o_valid), 64'd0);

    // Flush with skid full and a new word incoming
    i_ready = 1'b0;
    drive(1'b1, 32'h008000EF, 32'h300);
    step();
    chk("jal_flags", 64'(flags), 64'b1010001);
    chk("jal_imm", 64'(o_imm), 64'd8);
    drive(1'b1, 32'hFFC12283, 32'h304);
    step();
    chk("pre_flush_ready", 64'(o_ready), 64'd0);
    i_flush = 1'b1;
    drive(1'b1, 32'h00500093, 32'h308);
    step();
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    chk("flush_pc_kept", 64'(o_pc), 64'h300);
    i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("post_flush_valid", 64'(o_valid), 64'd0);

    // lw x5,-4(x2)
    drive(1'b1, 32'hFFC12283, 32'h304);
    step();
    chk("lw_flags", 64'(flags), 64'b1001010);
    chk("lw_imm", 64'(o_imm), 64'hFFFFFFFC);
    chk("lw_rd", 64'(o_rd), 64'd5);

    // All-ones word is illegal
    drive(1'b1, 32'hFFFFFFFF, 32'h400);
    step();
    chk("ill_valid", 64'(o_valid), 64'd1);
    chk("ill_flags", 64'(flags), 64'd0);
`ifdef DECODE_ILLEGAL_EN
    chk("ill_illegal", 64'(o_illegal), 64'd1);
`endif

    // Reset mid-transfer with output held and skid full
    i_ready = 1'b0;
    drive(1'b1, 32'h007302B3, 32'h500);
    step();
    drive(1'b1, 32'h0020A423, 32'h504);
    step();
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    chk("pre_rst_ready", 64'(o_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_pc", 64'(o_pc), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    i_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 64'(o_valid), 64'd0);
    step();
    chk("post_rst_valid2", 64'(o_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
